cpu_step_sequencer: RTL and testbench

Parametrised multi-cycle instruction sequencer for the MIPS core. It generalises the fixed FETCH/EXEC1/EXEC2 cycle to a FETCH phase followed by up to MAX_EXEC execute steps. Individual instructions may finish early, and the block adds a sticky halt mechanism plus performance counters. The datapath control decoder consumes state_o/step_o to select per-step control signals.

---
 rtl/cpu_step_sequencer.sv | 113 +++++++++++
 tb/tb_cpu_step_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_sequencer.sv
// Multi-cycle instruction sequencer: a FETCH phase followed by up to MAX_EXEC
// execute steps, with early finish, a sticky halt and two performance counters.
module cpu_step_sequencer #(
    parameter int MAX_EXEC = 2,
    parameter int STEP_W   = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              stall_i,
    input  logic              end_early_i,
    input  logic              halt_i,
    output logic [1:0]        state_o,
    output logic [STEP_W-1:0] step_o,
    output logic              fetch_o,
    output logic              last_o,
    output logic              retire_o,
    output logic [CNT_W-1:0]  active_cycles_o,
    output logic [CNT_W-1:0]  retired_o
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_HALTED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_EXEC - 1);

    if (MAX_EXEC < 1 || MAX_EXEC > 15) begin : g_bad_max_exec
        $error("cpu_step_sequencer: MAX_EXEC must be in 1..15");
    end
    if ((2 ** STEP_W) <= MAX_EXEC) begin : g_bad_step_w
        $error("cpu_step_sequencer: STEP_W too narrow for MAX_EXEC");
    end

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]  active_q, active_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              is_last;
    logic              is_retire;
    logic              not_halted;

    assign not_halted = (state_q != ST_HALTED);
    assign is_last    = (state_q == ST_EXEC) && ((step_q == LAST_STEP) || end_early_i);
    assign is_retire  = is_last && !stall_i;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_FETCH: begin
                if (!stall_i) begin
                    state_d = ST_EXEC;
                    step_d  = '0;
                end
            end
            ST_EXEC: begin
                if (!stall_i) begin
                    if (is_last) begin
                        step_d  = '0;
                        state_d = (halt_pend_q || halt_i) ? ST_HALTED : ST_FETCH;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
                step_d  = '0;
            end
            default: begin
                // The unused encoding recovers into a clean fetch.
                state_d = ST_FETCH;
                step_d  = '0;
            end
        endcase
    end

    // A halt request is remembered even while stalled so that it takes effect
    // at the next retirement, whichever cycle that turns out to be.
    assign halt_pend_d = halt_pend_q || (halt_i && not_halted);
    assign active_d    = not_halted ? active_q + CNT_W'(1) : active_q;
    assign retired_d   = is_retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_FETCH;
            step_q      <= '0;
            halt_pend_q <= 1'b0;
            active_q    <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            halt_pend_q <= halt_pend_d;
            active_q    <= active_d;
            retired_q   <= retired_d;
        end
    end

    assign state_o         = state_q;
    assign step_o          = step_q;
    assign fetch_o         = (state_q == ST_FETCH);
    assign last_o          = is_last;
    assign retire_o        = is_retire;
    assign active_cycles_o = active_q;
    assign retired_o       = retired_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Randomised bench for cpu_step_sequencer: three configurations share one
// stimulus stream and are each compared against a phase-level reference model.
module tb_cpu_step_sequencer;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic stall_i = 1'b0;
    logic end_early_i = 1'b0;
    logic halt_i = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: defaults; instance 1: MAX_EXEC=4, CNT_W=4; instance 2: MAX_EXEC=1, CNT_W=4.
    logic [1:0]  st0, st1, st2;
    logic [3:0]  sp0, sp1, sp2;
    logic        f0, f1, f2, l0, l1, l2, r0, r1, r2;
    logic [31:0] ac0, rt0;
    logic [3:0]  ac1, rt1, ac2, rt2;

    cpu_step_sequencer #(.MAX_EXEC(2), .STEP_W(4), .CNT_W(32)) u_dut0 (
        .clk(clk), .reset_i(reset_i), .stall_i(stall_i), .end_early_i(end_early_i),
        .halt_i(halt_i), .state_o(st0), .step_o(sp0), .fetch_o(f0), .last_o(l0),
        .retire_o(r0), .active_cycles_o(ac0), .retired_o(rt0));

    cpu_step_sequencer #(.MAX_EXEC(4), .STEP_W(4), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset_i(reset_i), .stall_i(stall_i), .end_early_i(end_early_i),
        .halt_i(halt_i), .state_o(st1), .step_o(sp1), .fetch_o(f1), .last_o(l1),
        .retire_o(r1), .active_cycles_o(ac1), .retired_o(rt1));

    cpu_step_sequencer #(.MAX_EXEC(1), .STEP_W(4), .CNT_W(4)) u_dut2 (
        .clk(clk), .reset_i(reset_i), .stall_i(stall_i), .end_early_i(end_early_i),
        .halt_i(halt_i), .state_o(st2), .step_o(sp2), .fetch_o(f2), .last_o(l2),
        .retire_o(r2), .active_cycles_o(ac2), .retired_o(rt2));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0=fetch 1=exec 2=halted, plain integer counters.
    int     mx[3]  = '{2, 4, 1};
    int     cw[3]  = '{32, 4, 4};
    int     ph[3];
    int     sp[3];
    bit     hp[3];
    longint act[3];
    longint ret[3];
    int     max_step_seen1 = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic longint wrap(input int k, input longint v);
        return v & ((64'd1 << cw[k]) - 64'd1);
    endfunction

    function automatic bit m_last(input int k);
        return (ph[k] == 1) && ((sp[k] == mx[k] - 1) || end_early_i);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ph[k] = 0; sp[k] = 0; hp[k] = 1'b0; act[k] = 0; ret[k] = 0;
        end
    endtask

    task automatic model_step(input bit s, input bit e, input bit h);
        for (int k = 0; k < 3; k++) begin
            bit done;
            done = (ph[k] == 1) && ((sp[k] == mx[k] - 1) || e) && !s;
            if (ph[k] != 2) act[k]++;
            if (done) ret[k]++;
            if (ph[k] == 0 && !s) begin
                ph[k] = 1; sp[k] = 0;
            end else if (ph[k] == 1 && !s) begin
                if (done) begin
                    ph[k] = (hp[k] || h) ? 2 : 0;
                    sp[k] = 0;
                end else begin
                    sp[k]++;
                end
            end
            if (h && ph[k] != 2) hp[k] = 1'b1;
        end
        // halt_pending sets on any non-halted edge; recheck using the pre-edge phase
        // is covered because a halted phase cannot leave, so setting it late is harmless.
    endtask

    task automatic check_inst(input int k, input string nm, input longint s, input longint p,
                              input longint f, input longint l, input longint r,
                              input longint a, input longint t);
        chk({nm, ".state"},   s, ph[k]);
        chk({nm, ".step"},    p, sp[k]);
        chk({nm, ".fetch"},   f, longint'(ph[k] == 0));
        chk({nm, ".last"},    l, longint'(m_last(k)));
        chk({nm, ".retire"},  r, longint'(m_last(k) && !stall_i));
        chk({nm, ".active"},  a, wrap(k, act[k]));
        chk({nm, ".retired"}, t, wrap(k, ret[k]));
    endtask

    task automatic check_all();
        check_inst(0, "i0", st0, sp0, f0, l0, r0, ac0, rt0);
        check_inst(1, "i1", st1, sp1, f1, l1, r1, ac1, rt1);
        check_inst(2, "i2", st2, sp2, f2, l2, r2, ac2, rt2);
        if (int'(sp1) > max_step_seen1) max_step_seen1 = int'(sp1);
    endtask

    // One clock: drive after the falling edge, check, let the edge happen, advance the model.
    task automatic cyc(input bit s, input bit e, input bit h);
        stall_i = s; end_early_i = e; halt_i = h;
        #1;
        check_all();
        @(posedge clk);
        model_step(s, e, h);
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        reset_i = 1'b1;
        #1;
        model_reset();
        stall_i = 1'b0; end_early_i = 1'b0; halt_i = 1'b0;
        #1;
        chk("rst.state0", st0, 0);
        chk("rst.step0", sp0, 0);
        chk("rst.act0", ac0, 0);
        chk("rst.ret0", rt0, 0);
        chk("rst.state1", st1, 0);
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("por.state", st0, 0);
        chk("por.fetch", f0, 1);
        reset_i = 1'b0;

        // Unstalled run: plain sequencing and 4-bit counter wrap on the MAX_EXEC=1 instance.
        for (int i = 0; i < 34; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (i == 8) begin
                chk("run9.retired", rt0, 3);
                chk("run9.active", ac0, 9);
                chk("run9.state", st0, 0);
            end
        end
        chk("wrap.active", ac2, 2);
        chk("wrap.retired", rt2, 1);

        // Stall for two cycles at EXEC step 1 of the default instance.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("stall.step_pre", sp0, 1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("stall.step_held", sp0, 1);
        chk("stall.active", ac0, 4);
        cyc(1'b0, 1'b0, 1'b0);
        chk("stall.retired", rt0, 1);

        // Early finish at step 1 on the MAX_EXEC=4 instance.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("early.state", st1, 0);
        chk("early.retired", rt1, 1);

        // Halt requested during fetch; halted state then ignores all inputs.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("halt.state", st0, 2);
        chk("halt.retired", rt0, 1);
        chk("halt.active", ac0, 3);

        // Random traffic with occasional asynchronous resets.
        max_step_seen1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(0, 99) < 25),
                    1'($urandom_range(0, 99) < 20),
                    1'($urandom_range(0, 999) < 15));
            end
        end
        chk("bound.step1", longint'(max_step_seen1 <= 3), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
